lms_ctr_spi_slave: RTL and testbench

LMS_CTR_SPI_SLAVE -- requirements
Module: lms_ctr_spi_slave

---
 rtl/lms_ctr_spi_slave.sv | 192 +++++++++++++++++++
 tb/tb_lms_ctr_spi_slave.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lms_ctr_spi_slave.sv
// SPI mode-0 slave (MSB first, 8-bit) with a two-cycle CPU register port.
// Define SPI_SLAVE_EOP_EN to add end-of-packet detection and the eop register.
module lms_ctr_spi_slave #(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe,
  input  logic        spi_select,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [2:0]  mem_addr,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata
);

  typedef enum logic {IDLE, ACTIVE} state_t;

`ifdef SPI_SLAVE_EOP_EN
  localparam bit EOP_EN = 1'b1;
`else
  localparam bit EOP_EN = 1'b0;
`endif
  localparam logic [15:0] CTRL_MASK = EOP_EN ? 16'h03DC : 16'h01DC;

  logic [SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync, vld_sync;
  logic sclk_s, ss_s, mosi_s, vld_s, sclk_q, armed;
  logic rd_q, wr_q, rd_acc, wr_acc, rd_stb, wr_stb, tx_wr;
  logic rise, fall, load, rx_done, eop_hit;
  state_t state;
  logic [2:0]  bitcnt;
  logic [7:0]  tx_shift, tx_holding, rx_shift, rx_holding, rx_byte;
  logic        tx_primed, rrdy, roe, toe, tur, eop;
  logic [15:0] ctrl, status, eop_val, rd_mux;

  assign sclk_s = sclk_sync[SYNC_STAGES-1];
  assign ss_s   = ss_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];
  assign vld_s  = vld_sync[SYNC_STAGES-1];

  assign rd_acc = spi_select & ~read_n;
  assign wr_acc = spi_select & ~write_n;
  assign rd_stb = rd_acc & ~rd_q;
  assign wr_stb = wr_acc & ~wr_q;
  assign tx_wr  = wr_stb & (mem_addr == 3'd1);

  assign rise    = (state == ACTIVE) & ~ss_s & sclk_s & ~sclk_q;
  assign fall    = (state == ACTIVE) & ~ss_s & ~sclk_s & sclk_q;
  assign load    = ((state == IDLE) & armed & ~ss_s) |
                   (fall & (bitcnt == 3'd0));
  assign rx_byte = {rx_shift[6:0], mosi_s};
  assign rx_done = rise & (bitcnt == 3'd7);
  assign eop_hit = EOP_EN &
                   ((rx_done & (rx_byte == eop_val[7:0])) |
                    (tx_wr & (data_from_cpu[7:0] == eop_val[7:0])));

  assign status = {6'b0, eop, roe | toe | tur, rrdy, ~tx_primed,
                   1'b0, toe, roe, tur, 2'b0};

  always_comb begin
    rd_mux = '0;
    case (mem_addr)
      3'd0:    rd_mux = {8'b0, rx_holding};
      3'd2:    rd_mux = status;
      3'd3:    rd_mux = ctrl;
      3'd6:    rd_mux = eop_val;
      default: rd_mux = '0;
    endcase
  end

  assign MISO          = tx_shift[7];
  assign MISO_oe       = ~ss_s;
  assign dataavailable = rrdy;
  assign readyfordata  = ~tx_primed;

`ifdef SPI_SLAVE_EOP_EN
  always_ff @(posedge clk) begin
    if (reset)
      eop_val <= '0;
    else if (wr_stb && mem_addr == 3'd6)
      eop_val <= data_from_cpu;
  end
`else
  assign eop_val = '0;
`endif

  // armed: SS_n must be seen high after reset before a frame may start
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync  <= '0;
      ss_sync    <= '1;
      mosi_sync  <= '0;
      vld_sync   <= '0;
      sclk_q     <= 1'b0;
      armed      <= 1'b0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
      state      <= IDLE;
      bitcnt     <= '0;
      tx_shift   <= '0;
      tx_holding <= '0;
      rx_shift   <= '0;
      rx_holding <= '0;
      tx_primed  <= 1'b0;
      rrdy       <= 1'b0;
      roe        <= 1'b0;
      toe        <= 1'b0;
      tur        <= 1'b0;
      eop        <= 1'b0;
      ctrl       <= '0;
      irq        <= 1'b0;
      data_to_cpu <= '0;
    end else begin
      sclk_sync <= SYNC_STAGES'({sclk_sync, SCLK});
      ss_sync   <= SYNC_STAGES'({ss_sync, SS_n});
      mosi_sync <= SYNC_STAGES'({mosi_sync, MOSI});
      vld_sync  <= SYNC_STAGES'({vld_sync, 1'b1});
      sclk_q    <= sclk_s;
      armed     <= armed | (vld_s & ss_s);
      rd_q      <= rd_acc;
      wr_q      <= wr_acc;
      irq       <= |(status & ctrl);

      if (rd_stb)
        data_to_cpu <= rd_mux;
      if (rd_stb && mem_addr == 3'd0)
        rrdy <= 1'b0;
      if (wr_stb) begin
        case (mem_addr)
          3'd2: begin
            eop <= 1'b0;
            roe <= 1'b0;
            toe <= 1'b0;
            tur <= 1'b0;
          end
          3'd3:    ctrl <= data_from_cpu & CTRL_MASK;
          default: ;
        endcase
      end

      // hardware events below override same-cycle CPU clears
      if (load) begin
        if (tx_primed) begin
          tx_shift  <= tx_holding;
          tx_primed <= 1'b0;
        end else begin
          tx_shift <= '0;
          tur      <= 1'b1;
        end
      end else if (fall) begin
        tx_shift <= {tx_shift[6:0], 1'b0};
      end

      if (tx_wr) begin
        if (tx_primed) begin
          toe <= 1'b1;
        end else begin
          tx_holding <= data_from_cpu[7:0];
          tx_primed  <= 1'b1;
        end
      end

      unique case (state)
        IDLE:
          if (armed && !ss_s) state <= ACTIVE;
        ACTIVE:
          if (ss_s) begin
            state  <= IDLE;
            bitcnt <= '0;
          end else if (rise) begin
            rx_shift <= rx_byte;
            bitcnt   <= bitcnt + 3'd1;
          end
      endcase

      if (rx_done) begin
        rx_holding <= rx_byte;
        rrdy       <= 1'b1;
        if (rrdy) roe <= 1'b1;
      end
      if (eop_hit) eop <= 1'b1;
    end
  end

endmodule

// File: tb/tb_lms_ctr_spi_slave.sv
// Bench for lms_ctr_spi_slave: transaction-level model plus directed frames.
// Honours SPI_SLAVE_EOP_EN the same way the design does.
module tb_lms_ctr_spi_slave;

`ifdef SPI_SLAVE_EOP_EN
  localparam bit EOP_EN = 1'b1;
`else
  localparam bit EOP_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset, SCLK, SS_n, MOSI;
  logic MISO, MISO_oe;
  logic spi_select, read_n, write_n;
  logic [2:0] mem_addr;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic irq, dataavailable, readyfordata;

  lms_ctr_spi_slave #(.SYNC_STAGES(2)) dut (
    .clk(clk), .reset(reset),
    .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe),
    .spi_select(spi_select), .read_n(read_n), .write_n(write_n),
    .mem_addr(mem_addr), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq),
    .dataavailable(dataavailable), .readyfordata(readyfordata)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 0;

  // model state
  logic [7:0]  m_hold, m_shift, m_rx;
  logic [15:0] m_ctrl, m_eopv;
  bit m_primed, m_rrdy, m_roe, m_toe, m_tur, m_eop;
  bit m_ss, m_armed, m_active;
  int m_bit;

  task automatic chk(input string nm, input logic [15:0] act,
                     input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] m_status();
    return {6'b0, m_eop, m_roe | m_toe | m_tur, m_rrdy, !m_primed,
            1'b0, m_toe, m_roe, m_tur, 2'b0};
  endfunction

  function automatic logic m_irq();
    return |(m_status() & m_ctrl);
  endfunction

  task automatic m_reset();
    m_hold = 0; m_shift = 0; m_rx = 0; m_ctrl = 0; m_eopv = 0;
    m_primed = 0; m_rrdy = 0; m_roe = 0; m_toe = 0; m_tur = 0;
    m_eop = 0; m_armed = m_ss; m_active = 0; m_bit = 0;
  endtask

  // next transmit byte: the primed byte if any, otherwise an underrun zero
  task automatic m_load();
    if (m_primed) begin
      m_shift = m_hold;
      m_primed = 0;
    end else begin
      m_shift = 8'h00;
      m_tur = 1;
    end
  endtask

  task automatic m_rx_byte(input logic [7:0] b);
    m_rx = b;
    if (m_rrdy) m_roe = 1;
    m_rrdy = 1;
    if (EOP_EN && b == m_eopv[7:0]) m_eop = 1;
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      chk("dataavailable", {15'b0, dataavailable}, {15'b0, m_rrdy});
      chk("readyfordata", {15'b0, readyfordata}, {15'b0, !m_primed});
      chk("irq", {15'b0, irq}, {15'b0, m_irq()});
      chk("MISO_oe", {15'b0, MISO_oe}, {15'b0, !m_ss});
      chk("MISO_idle", {15'b0, MISO}, {15'b0, m_shift[7]});
    end
  end

  task automatic cpu_write(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    chk_en = 0;
    spi_select = 1; write_n = 0; mem_addr = a; data_from_cpu = d;
    case (a)
      3'd1: begin
        if (EOP_EN && d[7:0] == m_eopv[7:0]) m_eop = 1;
        if (m_primed) m_toe = 1;
        else begin m_hold = d[7:0]; m_primed = 1; end
      end
      3'd2: begin m_eop = 0; m_roe = 0; m_toe = 0; m_tur = 0; end
      3'd3: m_ctrl = d & (EOP_EN ? 16'h03DC : 16'h01DC);
      3'd6: m_eopv = EOP_EN ? d : 16'h0;
      default: ;
    endcase
    repeat (2) @(negedge clk);
    spi_select = 0; write_n = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
  endtask

  task automatic cpu_read(input logic [2:0] a, output logic [15:0] d);
    logic [15:0] exp;
    @(negedge clk);
    chk_en = 0;
    spi_select = 1; read_n = 0; mem_addr = a;
    case (a)
      3'd0: begin exp = {8'h0, m_rx}; m_rrdy = 0; end
      3'd2: exp = m_status();
      3'd3: exp = m_ctrl;
      3'd6: exp = m_eopv;
      default: exp = 16'h0;
    endcase
    repeat (2) @(negedge clk);
    d = data_to_cpu;
    chk("model_read", d, exp);
    spi_select = 0; read_n = 1;
    repeat (3) @(negedge clk);
    chk_en = 1;
  endtask

  task automatic spi_start();
    @(negedge clk);
    chk_en = 0;
    SS_n = 0; m_ss = 0;
    m_active = m_armed; m_bit = 0;
    if (m_active) m_load();
    repeat (4) @(negedge clk);
  endtask

  task automatic spi_byte(input logic [7:0] b, input int n,
                          output logic [7:0] cap);
    chk_en = 0;
    cap = 0;
    for (int i = 0; i < n; i++) begin
      MOSI = b[7-i];
      repeat (4) @(negedge clk);
      chk("MISO_bit", {15'b0, MISO}, {15'b0, m_shift[7]});
      cap = {cap[6:0], MISO};
      SCLK = 1;
      if (m_active) begin
        m_bit++;
        if (m_bit == 8) begin m_rx_byte(b); m_bit = 0; end
      end
      repeat (4) @(negedge clk);
      SCLK = 0;
      if (m_active) begin
        if (m_bit == 0) m_load();
        else m_shift = m_shift << 1;
      end
    end
  endtask

  task automatic spi_stop();
    repeat (4) @(negedge clk);
    SS_n = 1; m_ss = 1;
    m_active = 0; m_bit = 0; m_armed = 1;
    repeat (6) @(negedge clk);
    chk_en = 1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    chk_en = 0;
    reset = 1;
    m_reset();
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (4) @(negedge clk);
    chk_en = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] d;
    logic [7:0] cap;
    reset = 1; SCLK = 0; SS_n = 1; MOSI = 0;
    spi_select = 0; read_n = 1; write_n = 1;
    mem_addr = 0; data_from_cpu = 0;
    m_ss = 1;
    m_reset();
    repeat (4) @(negedge clk);
    reset = 0;
    repeat (4) @(negedge clk);
    chk("rst_miso", {15'b0, MISO}, 16'h0);
    chk("rst_miso_oe", {15'b0, MISO_oe}, 16'h0);
    chk("rst_irq", {15'b0, irq}, 16'h0);
    chk("rst_dataavail", {15'b0, dataavailable}, 16'h0);
    chk("rst_readyfordata", {15'b0, readyfordata}, 16'h1);
    chk_en = 1;
    cpu_read(3'd2, d);
    chk("rst_status", d, 16'h0040);

    // A5 out, 3C in
    cpu_write(3'd1, 16'h00A5);
    spi_start(); spi_byte(8'h3C, 8, cap); spi_stop();
    chk("a5_miso_bits", {8'h0, cap}, 16'h00A5);
    cpu_read(3'd2, d);
    chk("a5_status", d, 16'h01C4);
    cpu_read(3'd0, d);
    chk("rx_3c", d, 16'h003C);
    cpu_write(3'd2, 16'h0);

    // overrun with iROE enabled
    cpu_write(3'd3, 16'h0008);
    spi_start();
    spi_byte(8'h11, 8, cap);
    spi_byte(8'h22, 8, cap);
    spi_stop();
    cpu_read(3'd2, d);
    chk("roe_status", d, 16'h01CC);
    chk("roe_irq", {15'b0, irq}, 16'h1);
    cpu_read(3'd0, d);
    chk("rx_22", d, 16'h0022);
    cpu_write(3'd2, 16'h0);
    cpu_write(3'd3, 16'h0);
    chk("irq_cleared", {15'b0, irq}, 16'h0);

    // underrun
    spi_start(); spi_byte(8'hFF, 8, cap); spi_stop();
    chk("tur_miso_zero", {8'h0, cap}, 16'h0000);
    cpu_read(3'd2, d);
    chk("tur_set", d & 16'h0004, 16'h0004);
    cpu_write(3'd2, 16'h0);
    cpu_read(3'd2, d);
    chk("tur_cleared", d, 16'h00C0);
    cpu_read(3'd0, d);

    // aborted partial frame, then a clean one
    spi_start(); spi_byte(8'hC3, 4, cap); spi_stop();
    chk("abort_no_rrdy", {15'b0, dataavailable}, 16'h0);
    spi_start(); spi_byte(8'h5A, 8, cap); spi_stop();
    cpu_read(3'd0, d);
    chk("rx_5a", d, 16'h005A);
    cpu_write(3'd2, 16'h0);

    // double tx write
    cpu_write(3'd1, 16'h0077);
    cpu_write(3'd1, 16'h0088);
    cpu_read(3'd2, d);
    chk("toe_status", d, 16'h0110);
    spi_start(); spi_byte(8'h81, 8, cap); spi_stop();
    chk("toe_first_kept", {8'h0, cap}, 16'h0077);
    cpu_read(3'd0, d);
    chk("rx_81", d, 16'h0081);
    cpu_write(3'd2, 16'h0);

    // end of packet
    cpu_write(3'd6, 16'h000D);
    cpu_read(3'd6, d);
    chk("eop_reg", d, EOP_EN ? 16'h000D : 16'h0000);
    spi_start(); spi_byte(8'h0D, 8, cap); spi_stop();
    cpu_read(3'd2, d);
    chk("eop_status", d, EOP_EN ? 16'h03C4 : 16'h01C4);
    cpu_read(3'd0, d);
    cpu_write(3'd2, 16'h0);

    // reset mid-frame with SS_n held low
    spi_start(); spi_byte(8'hE7, 3, cap);
    do_reset();
    spi_byte(8'h99, 8, cap);
    chk("post_rst_no_rx", {15'b0, dataavailable}, 16'h0);
    spi_stop();
    spi_start(); spi_byte(8'h3C, 8, cap); spi_stop();
    cpu_read(3'd0, d);
    chk("post_rst_rx", d, 16'h003C);

    repeat (4) @(negedge clk);
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
